// File: rtl/bus_pkg.sv
// Shared widths, command record and FSM encoding for the bus master port slice.
package bus_pkg;

    localparam int BUS_ADDR_W = 8;
    localparam int BUS_DATA_W = 32;

    typedef struct packed {
        logic                  we;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        OWN     = 2'd2,
        BACKOFF = 2'd3
    } state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO, head visible combinationally, no bypass.
// Push is ignored when full and pop is ignored when empty.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 41
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_dat,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dat,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dat   = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_dat;
    end

endmodule

// File: rtl/bus_master_port.sv
// Per-master requester front end: queues commands, requests the bus, issues one beat/cycle while owned.
// First beat two cycles after accept; read data one cycle after its beat; cmd_ready drops when the queue is full.
module bus_master_port import bus_pkg::*; #(
    parameter int ADDR_W   = BUS_ADDR_W,
    parameter int DATA_W   = BUS_DATA_W,
    parameter int DEPTH    = 4,
    parameter int HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_we,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    output logic              o_m_req,
    input  logic              i_m_grant,
    output logic              o_m_valid,
    output logic              o_m_we,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [DATA_W-1:0] o_m_wdata,
    input  logic [DATA_W-1:0] i_s_rdata,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_busy
);

    localparam int CMD_W  = 1 + ADDR_W + DATA_W;
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int HOLD_W = $clog2(HOLD_MAX+1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [HOLD_W-1:0] w_hold_inc;
    logic              r_m_req;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;

    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_beat;
    logic              w_drain;
    logic [CMD_W-1:0]  w_head;
    logic              w_head_we;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_wdata;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_dat   ({i_cmd_we, i_cmd_addr, i_cmd_wdata}),
        .i_pop   (w_beat),
        .o_dat   (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {w_head_we, w_head_addr, w_head_wdata} = w_head;

    assign w_push     = i_cmd_valid & ~w_full;
    // A grant seen while not requesting is stale and must never issue a beat.
    assign w_beat     = r_m_req & i_m_grant & ~w_empty;
    assign w_drain    = (w_count == CNT_W'(1)) & ~w_push;
    assign w_hold_inc = r_hold + 1'b1;

    assign o_cmd_ready = ~w_full;
    assign o_m_req     = r_m_req;
    assign o_m_valid   = w_beat;
    assign o_m_we      = w_beat & w_head_we;
    assign o_m_addr    = w_beat ? w_head_addr  : '0;
    assign o_m_wdata   = w_beat ? w_head_wdata : '0;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_data   = r_rd_data;
    assign o_busy      = ~w_empty | r_m_req;

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        case (r_state)
            IDLE: begin
                w_hold_nxt = '0;
                if (!w_empty) w_state_nxt = REQ;
            end
            REQ, OWN: begin
                if (w_beat) begin
                    if (w_drain) begin
                        w_state_nxt = IDLE;
                        w_hold_nxt  = '0;
                    end else if (w_hold_inc >= HOLD_W'(HOLD_MAX)) begin
                        w_state_nxt = BACKOFF;
                        w_hold_nxt  = '0;
                    end else begin
                        w_state_nxt = OWN;
                        w_hold_nxt  = w_hold_inc;
                    end
                end else if (r_state == OWN) begin
                    // Preempted: re-request and restart the hold window.
                    w_state_nxt = REQ;
                    w_hold_nxt  = '0;
                end
            end
            BACKOFF: begin
                w_state_nxt = REQ;
                w_hold_nxt  = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_hold     <= '0;
            r_m_req    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold     <= w_hold_nxt;
            r_m_req    <= (w_state_nxt == REQ) || (w_state_nxt == OWN);
            r_rd_valid <= w_beat & ~w_head_we;
            if (w_beat && !w_head_we) r_rd_data <= i_s_rdata;
        end
    end

endmodule

// File: doc/bus_master_port.md
# bus_master_port

Requester-side front end for the 3-master fixed-priority bus arbiter: one instance sits in front of each master (m0/m1/m2). It queues single-beat read/write commands, drives the master's `req` line toward the arbiter, issues beats only while it owns the bus, and returns read data. A hold limit drops `req` periodically so a high-priority master cannot starve the others indefinitely.

## Interface
- `ADDR_W`, 8, bus address width
- `DATA_W`, 32, bus data width
- `DEPTH`, 4, command FIFO entries (power of 2, ≥2)
- `HOLD_MAX`, 4, max consecutive beats before a forced 1-cycle release (≥1)

- `clk`  in  1  clock
- `reset_n`  in  1  reset, synchronous, active-low
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  FIFO can accept; `= !full`
- `cmd_we`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  command address
- `cmd_wdata`  in  DATA_W  write data (ignored for reads)
- `m_req`  out  1  registered request to arbiter
- `m_grant`  in  1  registered grant from arbiter
- `m_valid`  out  1  beat on bus this cycle
- `m_we`  out  1  beat is write
- `m_addr`  out  ADDR_W  beat address
- `m_wdata`  out  DATA_W  beat write data
- `s_rdata`  in  DATA_W  slave read data, valid in the beat cycle
- `rd_valid`  out  1  read response strobe (1 cycle)
- `rd_data`  out  DATA_W  read response data
- `busy`  out  1  FIFO non-empty or `m_req` high

## Operation
- Push when `cmd_valid & cmd_ready`; FIFO stores {we, addr, wdata} in order.
- Beat condition: `m_valid = m_req & m_grant & !empty` (combinational from registered `m_req`, input `m_grant`, FIFO count). `m_we/m_addr/m_wdata` = FIFO head; driven to 0 when `m_valid` = 0.
- A beat pops the head at the closing edge. Read beat: capture `s_rdata` into `rd_data`, pulse `rd_valid` next cycle.
- `m_req` is registered and equals 1 in states REQ and OWN only.
- States:
  - IDLE: `m_req` = 0. → REQ when FIFO non-empty.
  - REQ: `m_req` = 1, waiting. Beat → OWN, `hold_cnt` = 1. FIFO becomes empty after the pop → IDLE.
  - OWN: each beat increments `hold_cnt`. `m_grant` low (preempted) → REQ, `hold_cnt` = 0. Pop empties FIFO with no simultaneous push → IDLE. `hold_cnt` reaches HOLD_MAX with FIFO still non-empty → BACKOFF.
  - BACKOFF: `m_req` = 0 for exactly one cycle, `hold_cnt` = 0 → REQ.
- Stale grant (grant high while `m_req` = 0, e.g. the cycle after a release, or arbiter parking on m0) never produces a beat.
- Simultaneous push and pop: count unchanged; when not full, both occur in the same cycle.
- Push while full: blocked (`cmd_ready` = 0); no data loss.
- Reset, including mid-beat: FIFO flushed, state IDLE, all outputs 0. An in-flight read produces no `rd_valid`.

## Timing
- Reset values: `cmd_ready` = 1; `m_req`, `m_valid`, `m_we`, `m_addr`, `m_wdata`, `rd_valid`, `rd_data`, `busy` = 0.
- Command accepted at edge t. `m_req` rises at t+1. Arbiter samples it at that edge's successor, so the earliest grant and first beat occur in cycle t+2.
- Read beat in cycle n gives `rd_valid`/`rd_data` in cycle n+1.
- Sustained throughput while granted: 1 beat/cycle up to HOLD_MAX beats, then 1 dead cycle (BACKOFF) plus 1 re-request cycle before the next possible grant.
- On preemption, the beat is lost only for the cycles where grant is low. No beat is dropped or duplicated; the head stays until popped.

## Structure
- Package `bus_pkg`: ADDR_W/DATA_W defaults, command struct typedef {we, addr, wdata}, state enum {IDLE, REQ, OWN, BACKOFF}.
- Sub-module `cmd_fifo`: synchronous FIFO (DEPTH, width 1+ADDR_W+DATA_W), with count, full, and empty outputs, and no bypass path.
- Top holds the FSM, `hold_cnt` (width clog2(HOLD_MAX+1)), read-return register, and output gating.

## Test plan
- Reset then idle: all outputs 0, `cmd_ready` = 1. Hold `m_grant` = 1 (parked) with no commands → `m_valid` never 1.
- Push write {addr 0x10, data 0xDEADBEEF} at t, grant follows `m_req` by 1 cycle → `m_req` high at t+1, `m_valid`/`m_we` = 1 at t+2 with matching addr/data, `m_req` 0 at t+3.
- Push read {addr 0x20}, `s_rdata` = 0x12345678 in the beat cycle → `rd_valid` = 1, `rd_data` = 0x12345678 exactly one cycle later, for one cycle.
- Push 6 commands with HOLD_MAX = 4 and grant always echoing req → beats 1–4 back-to-back, `m_req` low 1 cycle, 2 remaining beats follow. Addresses come out in push order; `cmd_ready` low while 4 entries are held.
- Preemption: drop `m_grant` for 3 cycles mid-queue → no `m_valid` in those cycles, `hold_cnt` reset, and the same head beat is issued once grant returns (no duplicate, no loss).
- Assert `reset_n` = 0 during a read beat with 3 entries queued → next cycle FIFO empty, `m_req` = 0, no `rd_valid`, `cmd_ready` = 1.
